// File: rtl/aes_mseq.sv
// Time-multiplexed AES byte-transform unit: SubBytes, SubBytes+ShiftRows half-columns and
// MixColumns on two 32-bit operands. S-box work is spread over 4/NLANE cycles on NLANE lanes.
module aes_mseq #(
    parameter int NLANE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        hi,
    input  logic        inv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err
);
    localparam int NSTEP = 4 / NLANE;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_SUB  = 2'd0;
    localparam logic [1:0] OP_SBSR = 2'd1;
    localparam logic [1:0] OP_MIX  = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x14, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(x3, x3);
        x12  = gmul(x12, x12);
        x14  = gmul(x12, x2);
        x15  = gmul(x12, x3);
        x240 = x15;
        for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
        return gmul(x240, x14);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    // SBSR reads byte (-i mod 4) for output byte i in both directions; only the operand
    // choice differs, and hi simply swaps which operand each position uses.
    function automatic logic [7:0] sbox_src(input logic [1:0] o, input logic h, input logic iv,
                                            input logic [1:0] i, input logic [31:0] av,
                                            input logic [31:0] bv);
        logic [1:0] k;
        logic       from_b;
        k      = i;
        from_b = 1'b0;
        if (o == OP_SBSR) begin
            k      = 2'd0 - i;
            from_b = h ^ (i == (iv ? 2'd3 : 2'd1));
        end
        return from_b ? bv[8*k +: 8] : av[8*k +: 8];
    endfunction

    function automatic logic [7:0] mixm(input logic [7:0] w3, input logic [7:0] w2,
                                        input logic [7:0] w1, input logic [7:0] w0,
                                        input logic iv);
        if (iv)
            return gmul(w3, 8'h0e) ^ gmul(w2, 8'h0b) ^ gmul(w1, 8'h0d) ^ gmul(w0, 8'h09);
        return gmul(w3, 8'h02) ^ gmul(w2, 8'h03) ^ w1 ^ w0;
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_p0;
    logic          hi_p0, inv_p0;
    logic [31:0]   a_p0, b_p0;
    logic          accept, last;
    logic [31:0]   mix_res;

    logic [1:0] lane_idx [NLANE];
    logic [7:0] lane_src [NLANE];
    logic [7:0] lane_fwd [NLANE];
    logic [7:0] lane_inv [NLANE];
    logic [7:0] lane_out [NLANE];

    assign in_ready  = !rst && (state == S_IDLE || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign last      = (op_p0 == OP_MIX) || (op_p0 == OP_ILL) || (cnt == CW'(NSTEP - 1));

    for (genvar j = 0; j < NLANE; j++) begin : g_lane
        assign lane_idx[j] = 2'(32'(cnt) * NLANE + j);
        assign lane_src[j] = sbox_src(op_p0, hi_p0, inv_p0, lane_idx[j], a_p0, b_p0);
        assign lane_fwd[j] = sbox_fwd(lane_src[j]);
        assign lane_inv[j] = sbox_inv(lane_src[j]);
        assign lane_out[j] = (op_p0 == OP_SBSR && inv_p0) ? lane_inv[j] : lane_fwd[j];
    end

    assign mix_res = {mixm(a_p0[31:24], b_p0[23:16], b_p0[31:24], a_p0[23:16], inv_p0),
                      mixm(a_p0[23:16], a_p0[31:24], b_p0[23:16], b_p0[31:24], inv_p0),
                      mixm(a_p0[15:8],  b_p0[7:0],   b_p0[15:8],  a_p0[7:0],   inv_p0),
                      mixm(a_p0[7:0],   a_p0[15:8],  b_p0[7:0],   b_p0[15:8],  inv_p0)};

    // Request capture (p0): operands are only meaningful while BUSY, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= op;
            hi_p0  <= hi;
            inv_p0 <= inv;
            a_p0   <= a;
            b_p0   <= b;
        end
    end

    // Control and result register; a retire in DONE may coincide with the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            state <= S_BUSY;
            cnt   <= '0;
        end else if (state == S_BUSY) begin
            if (op_p0 == OP_MIX) begin
                out_data <= mix_res;
            end else if (op_p0 == OP_ILL) begin
                out_data <= '0;
            end else begin
                for (int j = 0; j < NLANE; j++) out_data[8*lane_idx[j] +: 8] <= lane_out[j];
            end
            out_err <= (op_p0 == OP_ILL);
            if (last) state <= S_DONE;
            else      cnt   <= cnt + 1'b1;
        end else if (state == S_DONE && out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_aes_mseq.sv
// Bench for aes_mseq: three instances (NLANE 1, 2, 4) against a table-driven reference model.
module tb_aes_mseq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [1:0]  op [3];
    logic        hi [3];
    logic        inv [3];
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data [3];
    logic        out_err [3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    aes_mseq #(.NLANE(1)) u_n1 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .hi(hi[0]), .inv(inv[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_err(out_err[0]));
    aes_mseq #(.NLANE(2)) u_n2 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .hi(hi[1]), .inv(inv[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_err(out_err[1]));
    aes_mseq #(.NLANE(4)) u_n4 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op(op[2]), .hi(hi[2]), .inv(inv[2]), .a(a[2]), .b(b[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .out_err(out_err[2]));

    function automatic int nl(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input int d);
        return (o < 2'd2) ? 4 / nl(d) : 1;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [7:0] t;
        t = x;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y);
        int acc, xx;
        acc = 0;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ xx;
            xx = xx * 2;
            if (xx > 255) xx = (xx - 256) ^ 'h1b;
        end
        return acc[7:0];
    endfunction

    function automatic logic [7:0] mx(input logic [7:0] w3, input logic [7:0] w2,
                                      input logic [7:0] w1, input logic [7:0] w0, input logic iv);
        if (iv) return gm(w3, 8'h0e) ^ gm(w2, 8'h0b) ^ gm(w1, 8'h0d) ^ gm(w0, 8'h09);
        return gm(w3, 8'h02) ^ gm(w2, 8'h03) ^ w1 ^ w0;
    endfunction

    // S-box built with the generator/log-walk method, inverse by table inversion.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic h, input logic iv,
                                              input logic [31:0] x, input logic [31:0] y);
        logic [7:0] A [4];
        logic [7:0] B [4];
        for (int i = 0; i < 4; i++) begin
            A[i] = x[8*i +: 8];
            B[i] = y[8*i +: 8];
        end
        case (o)
            2'd0: return {sb[A[3]], sb[A[2]], sb[A[1]], sb[A[0]]};
            2'd1: begin
                if (!iv && !h) return {sb[A[1]], sb[A[2]], sb[B[3]], sb[A[0]]};
                if (!iv &&  h) return {sb[B[1]], sb[B[2]], sb[A[3]], sb[B[0]]};
                if ( iv && !h) return {isb[B[1]], isb[A[2]], isb[A[3]], isb[A[0]]};
                return {isb[A[1]], isb[B[2]], isb[B[3]], isb[B[0]]};
            end
            2'd2: return {mx(A[3], B[2], B[3], A[2], iv), mx(A[2], A[3], B[2], B[3], iv),
                          mx(A[1], B[0], B[1], A[0], iv), mx(A[0], A[1], B[0], B[1], iv)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic present(input int d, input logic [1:0] o, input logic h, input logic iv,
                           input logic [31:0] x, input logic [31:0] y);
        op[d] = o; hi[d] = h; inv[d] = iv; a[d] = x; b[d] = y;
    endtask

    // One request from IDLE to retirement; returns what was observed.
    task automatic run_one(input int d, input logic [1:0] o, input logic h, input logic iv,
                           input logic [31:0] x, input logic [31:0] y, output logic rdy,
                           output logic [31:0] data, output logic err, output int lat);
        @(negedge clk);
        present(d, o, h, iv, x, y);
        in_valid[d] = 1'b1;
        out_ready[d] = 1'b0;
        rdy = in_ready[d];
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = out_data[d];
        err = out_err[d];
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) in_valid[d] = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (out_valid[d] !== 1'b0 || out_err[d] !== 1'b0 || out_data[d] !== 32'h0 || in_ready[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got v=%b e=%b d=%h r=%b want 0 0 00000000 0",
                         d, out_valid[d], out_err[d], out_data[d], in_ready[d]);
            end
            in_valid[d] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got r=%b v=%b want 1 0", d, in_ready[d], out_valid[d]);
            end
        end
    endtask

    task automatic check_run(input string name, input int d, input logic [1:0] o, input logic h,
                             input logic iv, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] want);
        logic rdy, err;
        logic [31:0] data;
        int lat;
        run_one(d, o, h, iv, x, y, rdy, data, err, lat);
        n_cmp++;
        if (rdy !== 1'b1 || data !== want || err !== (o == 2'd3) || lat != exp_lat(o, d)) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b data=%h err=%b lat=%0d want 1 %h %b %0d",
                     name, rdy, data, err, lat, want, (o == 2'd3), exp_lat(o, d));
        end
    endtask

    task automatic test_vectors();
        check_run("sub_n1", 0, 2'd0, 1'b0, 1'b0, 32'h00000053, 32'h0, 32'h636363ED);
        check_run("mix_fwd_n4", 2, 2'd2, 1'b0, 1'b0, 32'h13DB0000, 32'h45530000, 32'h4D8E0000);
        check_run("mix_inv_n4", 2, 2'd2, 1'b0, 1'b1, 32'h4D8E0000, 32'hBCA10000, 32'h13DB0000);
        check_run("sbsr_inv_n2", 1, 2'd1, 1'b0, 1'b1, 32'h63636363, 32'h00006300, 32'h00000000);
        check_run("sbsr_fwd_hi_n2", 1, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h63636363);
        check_run("illegal_n4", 2, 2'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic h, iv;
        logic [31:0] x, y;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 24; k++) begin
                o = 2'($urandom_range(0, 3));
                h = 1'($urandom);
                iv = 1'($urandom);
                x = $urandom;
                y = $urandom;
                check_run($sformatf("rand_n%0d_op%0d", nl(d), o), d, o, h, iv, x, y, ref_model(o, h, iv, x, y));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] x, held, want;
        int lat;
        x = $urandom;
        want = ref_model(2'd0, 1'b0, 1'b0, x, 32'h0);
        @(negedge clk);
        present(1, 2'd0, 1'b0, 1'b0, x, 32'h0);
        in_valid[1] = 1'b1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        in_valid[1] = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        held = out_data[1];
        n_cmp++;
        if (held !== want || lat != 2) begin
            n_bad++;
            $display("FAIL stall_result: got %h lat=%0d want %h lat=2", held, lat, want);
        end
        for (int k = 0; k < 5; k++) begin
            present(1, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom);
            in_valid[1] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== held || out_err[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h e=%b r=%b want 1 %h 0 0",
                         k, out_valid[1], out_data[1], out_err[1], in_ready[1], held);
            end
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(negedge clk);
        out_ready[1] = 1'b0;
        n_cmp++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || out_data[1] !== held) begin
            n_bad++;
            $display("FAIL stall_retire: got v=%b r=%b d=%h want 0 1 %h", out_valid[1], in_ready[1], out_data[1], held);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ro [9];
        logic rh [9];
        logic ri [9];
        logic [31:0] ra [9];
        logic [31:0] rb [9];
        logic [31:0] exp_q [$];
        logic err_q [$];
        int gap_q [$];
        logic [31:0] wd;
        logic we;
        int wg, idx, got, last, cyc;
        logic acc;
        for (int k = 0; k < 9; k++) begin
            ro[k] = 2'($urandom_range(0, 1));
            rh[k] = 1'($urandom);
            ri[k] = 1'($urandom);
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
        ro[6] = 2'd3;
        ro[7] = 2'd2;
        idx = 0;
        got = 0;
        last = 0;
        cyc = 0;
        @(negedge clk);
        present(0, ro[0], rh[0], ri[0], ra[0], rb[0]);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        while (got < 9 && cyc < 200) begin
            acc = in_valid[0] && in_ready[0];
            if (out_valid[0] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_spurious: got %h want no result", out_data[0]);
                end else begin
                    wd = exp_q.pop_front();
                    we = err_q.pop_front();
                    wg = gap_q.pop_front();
                    if (out_data[0] !== wd || out_err[0] !== we || (got > 0 && cyc - last != wg)) begin
                        n_bad++;
                        $display("FAIL b2b_result[%0d]: got %h err=%b gap=%0d want %h err=%b gap=%0d",
                                 got, out_data[0], out_err[0], cyc - last, wd, we, wg);
                    end
                end
                got++;
                last = cyc;
            end
            if (acc) begin
                exp_q.push_back(ref_model(ro[idx], rh[idx], ri[idx], ra[idx], rb[idx]));
                err_q.push_back(ro[idx] == 2'd3);
                gap_q.push_back(exp_lat(ro[idx], 0) + 1);
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 9) present(0, ro[idx], rh[idx], ri[idx], ra[idx], rb[idx]);
                else in_valid[0] = 1'b0;
            end
        end
        n_cmp++;
        if (got != 9) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d results want 9", got);
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [31:0] x;
        x = $urandom | 32'h1;
        @(negedge clk);
        present(0, 2'd0, 1'b0, 1'b0, x, 32'h0);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 || out_err[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got v=%b d=%h e=%b r=%b want 0 00000000 0 0",
                     out_valid[0], out_data[0], out_err[0], in_ready[0]);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid[0] !== 1'b0 || out_data[0] !== 32'h0) begin
                n_bad++;
                $display("FAIL rst_no_resume: got v=%b d=%h want 0 00000000", out_valid[0], out_data[0]);
            end
        end
        x = $urandom;
        check_run("after_rst_n1", 0, 2'd0, 1'b0, 1'b0, x, 32'h0, ref_model(2'd0, 1'b0, 1'b0, x, 32'h0));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            present(d, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        build_tables();
        test_reset();
        test_vectors();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_mseq.md
AES_MSEQ -- requirements
Module: aes_mseq

Interface
REQ-001 SHALL have parameter NLANE, default 4, number of time-multiplexed fwd+inv S-box lane pairs; legal values 1, 2 and 4.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  request valid.
REQ-006 in_ready  out  1  request may be accepted this cycle.
REQ-007 op  in  2  00=SUB, 01=SBSR, 10=MIX, 11=illegal.
REQ-008 hi  in  1  SBSR half select.
REQ-009 inv  in  1  inverse transform select (SBSR, MIX).
REQ-010 a  in  32  operand A; bytes a0 (bits 7:0) through a3 (bits 31:24).
REQ-011 b  in  32  operand B; bytes b0 through b3, same layout.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  32  result; bytes c0 (bits 7:0) through c3 (bits 31:24).
REQ-015 out_err  out  1  result came from an illegal op.

Function
REQ-016 Notation: S = AES forward S-box; Si = inverse S-box; m(w3,w2,w1,w0) = GF(2^8) sum of coefficients {02,03,01,01} (fwd) or {0E,0B,0D,09} (inv), applied in order w3..w0.
REQ-017 SUB: c_i = S(a_i) for i=0..3; inv ignored.
REQ-018 SBSR fwd: hi=0 gives c3..c0 = S(a1), S(a2), S(b3), S(a0); hi=1 gives S(b1), S(b2), S(a3), S(b0).
REQ-019 SBSR inv: hi=0 gives c3..c0 = Si(b1), Si(a2), Si(a3), Si(a0); hi=1 gives Si(a1), Si(b2), Si(b3), Si(b0).
REQ-020 MIX: c3 = m(a3,b2,b3,a2); c2 = m(a2,a3,b2,b3); c1 = m(a1,b0,b1,a0); c0 = m(a0,a1,b0,b1).
REQ-021 Illegal op: out_data = 0 and out_err = 1; otherwise out_err = 0.
REQ-022 FSM states: IDLE, BUSY, DONE.
REQ-023 in_ready = !rst && (IDLE || (DONE && out_ready)).
REQ-024 Accept occurs on any edge with in_valid && in_ready; at that edge op, hi, inv, a and b are registered and the state goes to BUSY.
REQ-025 Input changes while not accepting SHALL have no effect.
REQ-026 BUSY length N: 4/NLANE cycles for SUB and SBSR; 1 cycle for MIX and illegal ops.
REQ-027 S-box ops: BUSY cycle k (k=0..N-1) computes output bytes k*NLANE through k*NLANE+NLANE-1 into the result register.
REQ-028 Only NLANE forward and NLANE inverse S-box instances SHALL exist.
REQ-029 On the edge ending the last BUSY cycle: state goes to DONE, out_valid=1, out_data is complete.
REQ-030 Latency from accept edge to out_valid high SHALL be N cycles.
REQ-031 In DONE with out_ready=0: out_data and out_err stay stable and out_valid stays 1.
REQ-032 In DONE with out_ready=1 and in_valid=0: next state is IDLE with out_valid=0.
REQ-033 In DONE with out_ready=1 and in_valid=1: the result is retired and the new request accepted on the same edge (state goes to BUSY), giving zero bubble.
REQ-034 out_data changes only on an edge that ends a BUSY cycle, or on reset.
REQ-035 Sustained throughput: one result per N+1 cycles.

Reset
REQ-036 While rst=1 at an edge: state goes to IDLE; out_valid=0, out_data=0, out_err=0; lane counter = 0; in_ready=0 during the rst cycle.
REQ-037 Reset in BUSY or DONE SHALL abort and discard the in-flight request; no partial result becomes visible.
REQ-038 First accept is possible on the first edge after rst deasserts.

Verification
REQ-039 NLANE=1; SUB, a=0x00000053 -> out_data=0x636363ED, out_valid rises 4 cycles after accept, out_err=0.
REQ-040 NLANE=4; MIX fwd, a=0x13DB0000, b=0x45530000 -> 0x4D8E0000 after 1 cycle; then MIX inv, a=0x4D8E0000, b=0xBCA10000 -> 0x13DB0000.
REQ-041 NLANE=2; SBSR inv, hi=0, a=0x63636363, b=0x00006300 -> 0x00000000 after 2 cycles; fwd hi=1, a=b=0 -> 0x63636363.
REQ-042 Hold out_ready=0 for 5 cycles in DONE while toggling a, b and op -> out_data stable, in_ready=0, no second accept.
REQ-043 out_ready=1 with in_valid held high and back-to-back requests, NLANE=1 -> results in order, one every 5 cycles; op=11 in the stream -> 0x00000000 with out_err=1.
REQ-044 Assert rst in the 2nd BUSY cycle (NLANE=1) -> out_valid=0 and out_data=0 next cycle; the following request completes correctly.
